// File: rtl/rv_pkg.sv
// Shared constants and types for the RV fetch front end.
package rv_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, keeps one imem request in flight,
// holds the fetched word across stalls and flushes on redirect.
module fetch_unit
    import rv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_f,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic [XLEN-1:0] instr_f,
    output logic [XLEN-1:0] pc_f,
    output logic [XLEN-1:0] pcplus4_f,
    output logic            fetch_valid
);

    fetch_state_t    r_state;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_buf;
    logic            r_buf_valid;

    logic            w_present;
    logic            w_consume;
    logic [XLEN-1:0] w_pc_next;
    logic [XLEN-1:0] w_word;

    // A word is on offer either straight from memory (WAIT) or from the buffer (HOLD).
    assign w_present = !rst && ((r_state == WAIT && imem_rsp_valid) ||
                                (r_state == HOLD && r_buf_valid));
    assign w_pc_next = r_pc + 32'd4;
    assign w_word    = (r_state == HOLD) ? r_buf : imem_rsp_data;

    assign fetch_valid = w_present && !redirect;
    assign w_consume   = fetch_valid && !stall_f;

    // The next request goes out in the same cycle the current word is consumed.
    assign imem_req_valid = !rst && !redirect && (r_state == FETCH || w_consume);
    assign imem_req_addr  = (r_state == FETCH) ? r_pc : w_pc_next;

    assign instr_f   = fetch_valid ? w_word    : NOP_INSTR;
    assign pc_f      = fetch_valid ? r_pc      : '0;
    assign pcplus4_f = fetch_valid ? w_pc_next : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= FETCH;
            r_pc        <= RESET_PC;
            r_buf       <= NOP_INSTR;
            r_buf_valid <= 1'b0;
        end else if (redirect) begin
            r_pc        <= {redirect_pc[XLEN-1:2], 2'b00};
            r_buf_valid <= 1'b0;
            // A request still in flight must have its response swallowed first.
            if ((r_state == WAIT || r_state == DRAIN) && !imem_rsp_valid) begin
                r_state <= DRAIN;
            end else begin
                r_state <= FETCH;
            end
        end else begin
            case (r_state)
                FETCH: begin
                    if (imem_req_ready) begin
                        r_state <= WAIT;
                    end
                end
                WAIT, HOLD: begin
                    if (w_consume) begin
                        r_pc        <= w_pc_next;
                        r_buf_valid <= 1'b0;
                        r_state     <= imem_req_ready ? WAIT : FETCH;
                    end else if (r_state == WAIT && imem_rsp_valid) begin
                        r_buf       <= imem_rsp_data;
                        r_buf_valid <= 1'b1;
                        r_state     <= HOLD;
                    end
                end
                DRAIN: begin
                    if (imem_rsp_valid) begin
                        r_state <= FETCH;
                    end
                end
                default: r_state <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed stimulus, a latency-programmable imem model,
// and a scoreboard monitor checking every consumed word and accepted request.
module tb_fetch_unit;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] instr;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        stall_f;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic [31:0] instr_f;
    logic [31:0] pc_f;
    logic [31:0] pcplus4_f;
    logic        fetch_valid;

    int n_cmp = 0;
    int n_err = 0;
    int k = 1;

    exp_t        exp_q[$];
    logic [31:0] req_q[$];

    fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
        .clk            (clk),
        .rst            (rst),
        .stall_f        (stall_f),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_f        (instr_f),
        .pc_f           (pc_f),
        .pcplus4_f      (pcplus4_f),
        .fetch_valid    (fetch_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_c(input logic [31:0] pc, input logic [31:0] pc4, input logic [31:0] instr);
        exp_t e;
        e.pc = pc;
        e.pc4 = pc4;
        e.instr = instr;
        exp_q.push_back(e);
    endtask

    // Called at posedge+4; returns at posedge+4 of the cycle presenting target.
    task automatic wait_pc(input logic [31:0] target, input int budget);
        int  n = 0;
        bit  found = 1'b0;
        while (!found && n < budget) begin
            if (fetch_valid === 1'b1 && pc_f === target) begin
                found = 1'b1;
            end else begin
                @(posedge clk);
                #4;
                n++;
            end
        end
        n_cmp++;
        if (!found) begin
            n_err++;
            $display("FAIL wait_pc: pc %h never presented within %0d cycles", target, budget);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_fetch_valid"}, {31'd0, fetch_valid}, 32'd0);
        chk({tag, "_instr_f"}, instr_f, 32'h0000_0013);
        chk({tag, "_pc_f"}, pc_f, 32'd0);
        chk({tag, "_pcplus4_f"}, pcplus4_f, 32'd0);
        chk({tag, "_req_valid"}, {31'd0, imem_req_valid}, 32'd0);
    endtask

    // Instruction memory: one outstanding request, response k cycles after acceptance.
    initial begin
        bit          acc;
        logic [31:0] acc_addr;
        bit          pending = 1'b0;
        int          cnt = 0;
        logic [31:0] paddr = '0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            acc      = !rst && imem_req_valid && imem_req_ready;
            acc_addr = imem_req_addr;
            @(posedge clk);
            #1;
            imem_rsp_valid = 1'b0;
            if (rst) begin
                pending = 1'b0;
            end else begin
                if (acc) begin
                    pending = 1'b1;
                    cnt     = k - 1;
                    paddr   = acc_addr;
                end
                if (pending) begin
                    if (cnt == 0) begin
                        imem_rsp_valid = 1'b1;
                        imem_rsp_data  = {16'hC0DE, paddr[15:0]};
                        pending        = 1'b0;
                    end else begin
                        cnt--;
                    end
                end
            end
        end
    end

    // Scoreboard monitor: a word counts as consumed when valid, not stalled, not redirected.
    initial begin
        exp_t        e;
        logic [31:0] a;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (fetch_valid && !stall_f && !redirect) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL consume: unexpected word pc=%h instr=%h, none required", pc_f, instr_f);
                    end else begin
                        e = exp_q.pop_front();
                        chk("consume_pc", pc_f, e.pc);
                        chk("consume_pc4", pcplus4_f, e.pc4);
                        chk("consume_instr", instr_f, e.instr);
                        $display("consume pc=%h pc4=%h instr=%h", pc_f, pcplus4_f, instr_f);
                    end
                end
                if (imem_req_valid && imem_req_ready) begin
                    if (req_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL request: unexpected request addr=%h, none required", imem_req_addr);
                    end else begin
                        a = req_q.pop_front();
                        chk("request_addr", imem_req_addr, a);
                        $display("request addr=%h", imem_req_addr);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        stall_f = 1'b0;
        redirect = 1'b0;
        redirect_pc = '0;
        imem_req_ready = 1'b1;
        k = 1;

        push_c(32'h0000_0100, 32'h0000_0104, 32'hC0DE_0100);
        push_c(32'h0000_0104, 32'h0000_0108, 32'hC0DE_0104);
        push_c(32'h0000_0108, 32'h0000_010C, 32'hC0DE_0108);
        push_c(32'h0000_0200, 32'h0000_0204, 32'hC0DE_0200);
        push_c(32'h0000_0200, 32'h0000_0204, 32'hC0DE_0200);
        push_c(32'h0000_0204, 32'h0000_0208, 32'hC0DE_0204);
        push_c(32'h0000_0208, 32'h0000_020C, 32'hC0DE_0208);
        push_c(32'h0000_020C, 32'h0000_0210, 32'hC0DE_020C);
        push_c(32'hFFFF_FFFC, 32'h0000_0000, 32'hC0DE_FFFC);
        push_c(32'h0000_0000, 32'h0000_0004, 32'hC0DE_0000);
        req_q = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h200, 32'h204, 32'h200, 32'h204,
                  32'h208, 32'h20C, 32'h210, 32'hFFFF_FFFC, 32'h0, 32'h4};

        @(posedge clk);
        #4;
        chk_reset_outputs("in_reset");

        // Release reset: first request is RESET_PC.
        @(posedge clk);
        #1 rst = 1'b0;
        #3;
        chk("first_req_valid", {31'd0, imem_req_valid}, 32'd1);
        chk("first_req_addr", imem_req_addr, 32'h0000_0100);
        chk("first_fetch_valid", {31'd0, fetch_valid}, 32'd0);
        @(posedge clk);
        #4;
        chk("first_word_valid", {31'd0, fetch_valid}, 32'd1);
        chk("first_word_pc", pc_f, 32'h0000_0100);

        // Stall three cycles on 0x108.
        wait_pc(32'h0000_0108, 20);
        stall_f = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) begin
                @(posedge clk);
                #4;
            end
            chk("stall_valid", {31'd0, fetch_valid}, 32'd1);
            chk("stall_pc", pc_f, 32'h0000_0108);
            chk("stall_pc4", pcplus4_f, 32'h0000_010C);
            chk("stall_instr", instr_f, 32'hC0DE_0108);
            chk("stall_no_req", {31'd0, imem_req_valid}, 32'd0);
        end
        @(posedge clk);
        #1;
        stall_f = 1'b0;
        k = 3;
        #3;
        chk("release_req_valid", {31'd0, imem_req_valid}, 32'd1);
        chk("release_req_addr", imem_req_addr, 32'h0000_010C);

        // Redirect while waiting on a slow response: drain, then fetch 0x200.
        @(posedge clk);
        #1;
        redirect = 1'b1;
        redirect_pc = 32'h0000_0200;
        #3;
        chk("redir_wait_valid", {31'd0, fetch_valid}, 32'd0);
        chk("redir_wait_req", {31'd0, imem_req_valid}, 32'd0);
        @(posedge clk);
        #1 redirect = 1'b0;
        #3;
        chk("drain1_valid", {31'd0, fetch_valid}, 32'd0);
        chk("drain1_req", {31'd0, imem_req_valid}, 32'd0);
        @(posedge clk);
        #4;
        chk("drain2_valid", {31'd0, fetch_valid}, 32'd0);
        chk("drain2_req", {31'd0, imem_req_valid}, 32'd0);
        @(posedge clk);
        #4;
        chk("post_drain_req_valid", {31'd0, imem_req_valid}, 32'd1);
        chk("post_drain_req_addr", imem_req_addr, 32'h0000_0200);
        wait_pc(32'h0000_0200, 10);
        k = 1;

        // Redirect coinciding with a response; low address bits ignored.
        wait_pc(32'h0000_0204, 10);
        redirect = 1'b1;
        redirect_pc = 32'h0000_0203;
        #1;
        chk("redir_rsp_valid", {31'd0, fetch_valid}, 32'd0);
        chk("redir_rsp_req", {31'd0, imem_req_valid}, 32'd0);
        @(posedge clk);
        #1 redirect = 1'b0;
        #3;
        chk("redir_rsp_next_valid", {31'd0, imem_req_valid}, 32'd1);
        chk("redir_rsp_next_addr", imem_req_addr, 32'h0000_0200);

        // Memory not ready for two cycles: request must hold steady.
        wait_pc(32'h0000_0208, 10);
        imem_req_ready = 1'b0;
        #1;
        chk("nready0_valid", {31'd0, imem_req_valid}, 32'd1);
        chk("nready0_addr", imem_req_addr, 32'h0000_020C);
        @(posedge clk);
        #4;
        chk("nready1_valid", {31'd0, imem_req_valid}, 32'd1);
        chk("nready1_addr", imem_req_addr, 32'h0000_020C);
        chk("nready1_fetch", {31'd0, fetch_valid}, 32'd0);
        @(posedge clk);
        #1 imem_req_ready = 1'b1;
        #3;
        chk("nready2_valid", {31'd0, imem_req_valid}, 32'd1);
        chk("nready2_addr", imem_req_addr, 32'h0000_020C);

        // PC wrap at the top of the address space.
        wait_pc(32'h0000_0210, 10);
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        @(posedge clk);
        #1 redirect = 1'b0;
        #3;
        chk("wrap_req_addr", imem_req_addr, 32'hFFFF_FFFC);
        wait_pc(32'hFFFF_FFFC, 10);
        chk("wrap_pc4", pcplus4_f, 32'h0000_0000);
        chk("wrap_next_req", imem_req_addr, 32'h0000_0000);
        wait_pc(32'h0000_0000, 10);
        wait_pc(32'h0000_0004, 10);

        // Reset mid-transaction returns outputs to reset values at once.
        rst = 1'b1;
        #1;
        chk_reset_outputs("mid_reset");
        @(posedge clk);
        #4;
        chk_reset_outputs("mid_reset_hold");

        chk("exp_queue_empty", exp_q.size(), 32'd0);
        chk("req_queue_empty", req_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage producing the `instr_f`, `pc_f` and `pcplus4_f` words consumed by the F/D pipeline register. It owns the program counter and drives a single-outstanding valid/ready request port to instruction memory. It holds a fetched word while the pipeline stalls and discards in-flight fetches on a redirect. `fetch_valid` tells the hazard unit whether the F/D register should capture the word or clear itself.

## Interface
- `RESET_PC`, default `32'h0000_0000`: PC fetched first after reset.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset; one clock, asynchronous, active-high.
- `stall_f`  in  1  downstream hold; the F/D register is not enabled this cycle.
- `redirect`  in  1  branch/jump taken; flush fetch.
- `redirect_pc`  in  32  new PC. Bits [1:0] are ignored and treated as 0.
- `imem_req_valid`  out  1  request valid.
- `imem_req_ready`  in  1  memory accepts the request.
- `imem_req_addr`  out  32  word address of the request.
- `imem_rsp_valid`  in  1  response valid, at least 1 cycle after acceptance. No backpressure.
- `imem_rsp_data`  in  32  instruction word.
- `instr_f`  out  32  presented instruction; NOP `32'h0000_0013` when not valid.
- `pc_f`  out  32  PC of `instr_f`; 0 when not valid.
- `pcplus4_f`  out  32  `pc_f + 4`, modulo 2^32; 0 when not valid.
- `fetch_valid`  out  1  presented word is real. The hazard unit clears F/D when this is low.

## Operation
- Registers: `pc_q` (PC of the oldest unconsumed fetch), `buf_q` (one held instruction), `state`.
- Consume = `fetch_valid && !stall_f && !redirect`.
- At most one memory request outstanding.
- States:
  - FETCH: assert `imem_req_valid` with addr `pc_q`. On accept, go to WAIT. Any `imem_rsp_valid` in this state is ignored.
  - WAIT: on a response, present `imem_rsp_data` combinationally with `pc_f = pc_q` and `fetch_valid = 1`.
    - If consumed: `pc_q += 4`. In the same cycle, request addr `pc_q + 4`; go to WAIT if accepted, FETCH otherwise.
    - If stalled: capture the word into `buf_q` and go to HOLD.
  - HOLD: present `buf_q`. On consume, behave exactly as the consumed case in WAIT.
  - DRAIN: wait for the orphaned response, discard it, then go to FETCH.
- Redirect has priority over everything, in any state:
  - `imem_req_valid` is forced to 0 in that cycle.
  - `pc_q <= redirect_pc & ~3` and `buf_q` is invalidated.
  - `fetch_valid` goes to 0 in the same cycle.
  - Next state: WAIT with no response this cycle goes to DRAIN. WAIT with a response this cycle, FETCH, and HOLD go to FETCH. DRAIN stays DRAIN until its response arrives, then goes to FETCH.
- `imem_req_valid` and `fetch_valid` depend combinationally on `stall_f` and `redirect`. This path is intentional and documented.

## Timing
- Reset values:
  - `state` = FETCH, `pc_q` = RESET_PC, `buf_q` empty.
  - Outputs: `fetch_valid` = 0, `instr_f` = `32'h13`, `pc_f` = 0, `pcplus4_f` = 0, `imem_req_valid` = 1 from the first cycle after `rst` deasserts.
- Latency:
  - Request accepted at cycle N with the response at N+k: the word is presented at N+k and captured by F/D at the N+k edge if not stalled.
  - With k=1 and `imem_req_ready` = 1, throughput is 1 instruction per cycle.
- Stall: a presented word remains stable on all outputs across any number of stall cycles. No new request is issued while stalled.
- Redirect at cycle R: the first request to `redirect_pc` is issued at R+1, or after the drain if one is needed.
- Reset mid-transaction: everything returns to reset values at once. Instruction memory is reset with the same `rst`.

## Structure
- `rv_pkg` holds:
  - `NOP_INSTR = 32'h0000_0013`.
  - `fetch_state_t` enum {FETCH, WAIT, HOLD, DRAIN}.
  - `XLEN = 32`.
- Single module with no sub-module: the buffer is one register plus a valid bit.

## Test plan
- Reset with `RESET_PC` = `32'h100`, memory with k=1 and ready always high:
  - First request addr `0x100`.
  - `fetch_valid` first high 1 cycle after that request is accepted, with `pc_f = 0x100` and `pcplus4_f = 0x104`.
  - Then one word per cycle at `0x104`, `0x108`, and so on.
- `stall_f` held high for 3 cycles while `0x108` is presented: outputs are frozen and there is no request. On release, the word is consumed and the `0x10C` request is issued the same cycle.
- Redirect to `0x200` while in WAIT with k=3:
  - The stale response is discarded in DRAIN and `fetch_valid` stays 0 until it arrives.
  - The next request is addr `0x200`.
- Redirect and `imem_rsp_valid` in the same cycle: the word is dropped and the next request is `0x200` one cycle later. `redirect_pc = 0x203` yields addr `0x200`.
- Memory with `imem_req_ready` low for 2 cycles: `imem_req_valid` and addr stay stable until accepted.
- `pc_q = 0xFFFF_FFFC`: `pcplus4_f = 0x0000_0000` and the next request addr is `0x0`.
